rename_alloc_unit: RTL and testbench

Register-rename and physical-register allocation stage. It drives the reorder buffer's allocate interface (alloc_valid / alloc_dest_arch / alloc_dest_phys, handshaken by alloc_accepted). It consumes the same commit stream the ROB emits to return physical registers to the free pool. It also restores the speculative rename state when recover is asserted.

---
 rtl/rename_alloc_unit.sv | 157 +++++++++++++++
 tb/tb_rename_alloc_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_alloc_unit.sv
// Register rename and physical-register allocation: speculative and committed
// rename tables, a lowest-index free-list pick, and a registered ROB allocate port.
module rename_alloc_unit #(
  parameter  int NUM_ARCH = 32,
  parameter  int NUM_PHYS = 64,
  parameter  int PHYS_W   = 6,
  localparam int ARCH_W   = $clog2(NUM_ARCH),
  localparam int CNT_W    = PHYS_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [ARCH_W-1:0] dec_dest_arch,
  input  logic [ARCH_W-1:0] dec_src1_arch,
  input  logic [ARCH_W-1:0] dec_src2_arch,
  output logic              dec_ready,
  output logic              alloc_valid,
  output logic [ARCH_W-1:0] alloc_dest_arch,
  output logic [PHYS_W-1:0] alloc_dest_phys,
  output logic [PHYS_W-1:0] alloc_src1_phys,
  output logic [PHYS_W-1:0] alloc_src2_phys,
  input  logic              alloc_accepted,
  input  logic              commit_valid,
  input  logic [ARCH_W-1:0] commit_dest_arch,
  input  logic [PHYS_W-1:0] commit_dest_phys,
  input  logic              recover,
  output logic [CNT_W-1:0]  free_count
);

  typedef logic [PHYS_W-1:0] tag_t;

  localparam logic [NUM_PHYS-1:0] FREE_RST =
    {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

  tag_t                spec_rat_q [NUM_ARCH];
  tag_t                spec_rat_d [NUM_ARCH];
  tag_t                comm_rat_q [NUM_ARCH];
  tag_t                comm_rat_d [NUM_ARCH];
  tag_t                ident_rat  [NUM_ARCH];
  logic [NUM_PHYS-1:0] free_map_q, free_map_d;
  logic [NUM_PHYS-1:0] used_map_q, used_map_d;
  logic [CNT_W-1:0]    free_count_q, free_count_d;

  logic                alloc_valid_q, alloc_valid_d;
  logic [ARCH_W-1:0]   alloc_dest_arch_q, alloc_dest_arch_d;
  tag_t                alloc_dest_phys_q, alloc_dest_phys_d;
  tag_t                alloc_src1_phys_q, alloc_src1_phys_d;
  tag_t                alloc_src2_phys_q, alloc_src2_phys_d;

  logic accept;
  logic need_alloc;
  logic commit_en;
  tag_t commit_old;
  tag_t pick_tag;

  for (genvar g = 0; g < NUM_ARCH; g++) begin : g_ident
    assign ident_rat[g] = tag_t'(g);
  end

  // free_count_q is the exact popcount of free_map_q, so a nonzero count
  // guarantees the picker below finds a free tag.
  assign dec_ready  = !recover && (!alloc_valid_q || alloc_accepted) &&
                      ((free_count_q != '0) || (dec_dest_arch == '0));
  assign accept     = dec_valid && dec_ready;
  assign need_alloc = accept && (dec_dest_arch != '0);
  assign commit_en  = commit_valid && (commit_dest_arch != '0);
  assign commit_old = comm_rat_q[commit_dest_arch];

  // Downward scan: the last hit written is the lowest-index free tag.
  always_comb begin
    pick_tag = '0;
    for (int i = NUM_PHYS - 1; i >= 0; i--) begin
      if (free_map_q[i]) pick_tag = tag_t'(i);
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets its default first, so no path leaves one unassigned and no latch is inferred.
    comm_rat_d        = comm_rat_q;
    spec_rat_d        = spec_rat_q;
    used_map_d        = used_map_q;
    free_map_d        = free_map_q;
    alloc_valid_d     = alloc_valid_q;
    alloc_dest_arch_d = alloc_dest_arch_q;
    alloc_dest_phys_d = alloc_dest_phys_q;
    alloc_src1_phys_d = alloc_src1_phys_q;
    alloc_src2_phys_d = alloc_src2_phys_q;

    if (commit_en) begin
      comm_rat_d[commit_dest_arch] = commit_dest_phys;
      used_map_d[commit_old]       = 1'b0;
      used_map_d[commit_dest_phys] = 1'b1;
      free_map_d[commit_old]       = 1'b1;
    end

    if (recover) begin
      // Restore from the committed view including this cycle's commit.
      spec_rat_d    = comm_rat_d;
      free_map_d    = ~used_map_d;
      alloc_valid_d = 1'b0;
    end else if (accept) begin
      alloc_valid_d     = 1'b1;
      alloc_dest_arch_d = dec_dest_arch;
      alloc_src1_phys_d = spec_rat_q[dec_src1_arch];
      alloc_src2_phys_d = spec_rat_q[dec_src2_arch];
      alloc_dest_phys_d = '0;
      if (need_alloc) begin
        free_map_d[pick_tag]      = 1'b0;
        spec_rat_d[dec_dest_arch] = pick_tag;
        alloc_dest_phys_d         = pick_tag;
      end
    end else if (alloc_accepted) begin
      alloc_valid_d = 1'b0;
    end

    free_count_d = '0;
    for (int i = 0; i < NUM_PHYS; i++) begin
      free_count_d = free_count_d + CNT_W'(free_map_d[i]);
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the same pre-edge values.
  // NOTE: the rename tables are reset to identity maps because they are architectural state, not scratch storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      spec_rat_q        <= ident_rat;
      comm_rat_q        <= ident_rat;
      free_map_q        <= FREE_RST;
      used_map_q        <= ~FREE_RST;
      free_count_q      <= CNT_W'(NUM_PHYS - NUM_ARCH);
      alloc_valid_q     <= 1'b0;
      alloc_dest_arch_q <= '0;
      alloc_dest_phys_q <= '0;
      alloc_src1_phys_q <= '0;
      alloc_src2_phys_q <= '0;
    end else begin
      spec_rat_q        <= spec_rat_d;
      comm_rat_q        <= comm_rat_d;
      free_map_q        <= free_map_d;
      used_map_q        <= used_map_d;
      free_count_q      <= free_count_d;
      alloc_valid_q     <= alloc_valid_d;
      alloc_dest_arch_q <= alloc_dest_arch_d;
      alloc_dest_phys_q <= alloc_dest_phys_d;
      alloc_src1_phys_q <= alloc_src1_phys_d;
      alloc_src2_phys_q <= alloc_src2_phys_d;
    end
  end

  assign alloc_valid     = alloc_valid_q;
  assign alloc_dest_arch = alloc_dest_arch_q;
  assign alloc_dest_phys = alloc_dest_phys_q;
  assign alloc_src1_phys = alloc_src1_phys_q;
  assign alloc_src2_phys = alloc_src2_phys_q;
  assign free_count      = free_count_q;

endmodule

// File: tb/tb_rename_alloc_unit.sv
// Self-checking bench for rename_alloc_unit: directed scenarios plus a random
// run against a set-based model fed by a bench-side in-order ROB queue.
module tb_rename_alloc_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid;
  logic [4:0] dec_dest_arch, dec_src1_arch, dec_src2_arch;
  logic       dec_ready;
  logic       alloc_valid;
  logic [4:0] alloc_dest_arch;
  logic [5:0] alloc_dest_phys, alloc_src1_phys, alloc_src2_phys;
  logic       alloc_accepted;
  logic       commit_valid;
  logic [4:0] commit_dest_arch;
  logic [5:0] commit_dest_phys;
  logic       recover;
  logic [6:0] free_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_spec [32];
  int m_comm [32];
  bit m_free [64];
  bit m_av;
  int m_arch, m_phys, m_s1, m_s2;
  typedef struct { int arch; int phys; } rob_t;
  rob_t rob_q [$];

  rename_alloc_unit dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_dest_arch(dec_dest_arch),
    .dec_src1_arch(dec_src1_arch), .dec_src2_arch(dec_src2_arch),
    .dec_ready(dec_ready),
    .alloc_valid(alloc_valid), .alloc_dest_arch(alloc_dest_arch),
    .alloc_dest_phys(alloc_dest_phys), .alloc_src1_phys(alloc_src1_phys),
    .alloc_src2_phys(alloc_src2_phys), .alloc_accepted(alloc_accepted),
    .commit_valid(commit_valid), .commit_dest_arch(commit_dest_arch),
    .commit_dest_phys(commit_dest_phys), .recover(recover),
    .free_count(free_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    dec_valid = 0; dec_dest_arch = 0; dec_src1_arch = 0; dec_src2_arch = 0;
    alloc_accepted = 0; commit_valid = 0; commit_dest_arch = 0;
    commit_dest_phys = 0; recover = 0;
  endtask

  task automatic offer(input int d, input int s1, input int s2);
    dec_valid = 1; dec_dest_arch = 5'(d); dec_src1_arch = 5'(s1); dec_src2_arch = 5'(s2);
  endtask

  task automatic apply_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  function automatic int m_count();
    int n = 0;
    for (int t = 0; t < 64; t++) n += int'(m_free[t]);
    return n;
  endfunction

  function automatic int m_lowest();
    for (int t = 0; t < 64; t++) if (m_free[t]) return t;
    return 0;
  endfunction

  task automatic m_init();
    for (int a = 0; a < 32; a++) begin m_spec[a] = a; m_comm[a] = a; end
    for (int t = 0; t < 64; t++) m_free[t] = (t >= 32);
    m_av = 0; m_arch = 0; m_phys = 0; m_s1 = 0; m_s2 = 0;
    rob_q.delete();
  endtask

  task automatic test_reset();
    idle();
    reset = 1; dec_valid = 1; dec_dest_arch = 3; commit_valid = 1;
    commit_dest_arch = 4; commit_dest_phys = 40;
    tick();
    reset = 0; idle(); dec_dest_arch = 3;
    #1;
    checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL reset_alloc_valid: got %0d expected 0", alloc_valid); end
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL reset_free_count: got %0d expected 32", free_count); end
    checks++; if (alloc_dest_phys !== 6'd0) begin errors++; $display("FAIL reset_dest_phys: got %0d expected 0", alloc_dest_phys); end
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_dec_ready: got %0d expected 1", dec_ready); end
  endtask

  task automatic test_first_alloc();
    apply_reset();
    offer(5, 5, 6);
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %0d expected 1", dec_ready); end
    tick(); idle();
    checks++; if (alloc_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %0d expected 1", alloc_valid); end
    checks++; if (alloc_dest_arch !== 5'd5) begin errors++; $display("FAIL first_dest_arch: got %0d expected 5", alloc_dest_arch); end
    checks++; if (alloc_dest_phys !== 6'd32) begin errors++; $display("FAIL first_dest_phys: got %0d expected 32", alloc_dest_phys); end
    checks++; if (alloc_src1_phys !== 6'd5) begin errors++; $display("FAIL first_src1: got %0d expected 5", alloc_src1_phys); end
    checks++; if (alloc_src2_phys !== 6'd6) begin errors++; $display("FAIL first_src2: got %0d expected 6", alloc_src2_phys); end
    checks++; if (free_count !== 7'd31) begin errors++; $display("FAIL first_free_count: got %0d expected 31", free_count); end
  endtask

  task automatic test_fill_free_list();
    apply_reset();
    alloc_accepted = 1;
    for (int i = 0; i < 32; i++) begin
      offer((i % 31) + 1, 0, 0);
      #1;
      checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %0d expected 1", i, dec_ready); end
      tick();
      checks++; if (alloc_dest_phys !== 6'(32 + i)) begin errors++; $display("FAIL fill_tag[%0d]: got %0d expected %0d", i, alloc_dest_phys, 32 + i); end
      checks++; if (free_count !== 7'(31 - i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, free_count, 31 - i); end
    end
    dec_valid = 0; dec_dest_arch = 3;
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL empty_ready_x3: got %0d expected 0", dec_ready); end
    dec_dest_arch = 0;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL empty_ready_x0: got %0d expected 1", dec_ready); end
    idle();
  endtask

  task automatic test_hold();
    apply_reset();
    offer(1, 2, 3);
    tick();
    offer(2, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %0d expected 0", k, dec_ready); end
      tick();
      checks++; if ({alloc_valid, alloc_dest_arch, alloc_dest_phys, alloc_src1_phys, alloc_src2_phys} !== {1'b1, 5'd1, 6'd32, 6'd2, 6'd3})
        begin errors++; $display("FAIL hold_outputs[%0d]: got v=%0d a=%0d p=%0d s1=%0d s2=%0d expected 1/1/32/2/3", k, alloc_valid, alloc_dest_arch, alloc_dest_phys, alloc_src1_phys, alloc_src2_phys); end
    end
    alloc_accepted = 1;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %0d expected 1", dec_ready); end
    tick();
    checks++; if (alloc_dest_phys !== 6'd33) begin errors++; $display("FAIL hold_next_tag: got %0d expected 33", alloc_dest_phys); end
    idle();
  endtask

  task automatic test_commit_free();
    apply_reset();
    offer(5, 0, 0);
    tick();
    idle(); alloc_accepted = 1;
    tick();
    idle();
    commit_valid = 1; commit_dest_arch = 5; commit_dest_phys = 32;
    tick();
    idle();
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL commit_free_count: got %0d expected 32", free_count); end
    offer(9, 5, 0);
    tick();
    idle();
    checks++; if (alloc_dest_phys !== 6'd5) begin errors++; $display("FAIL commit_reuse_tag: got %0d expected 5", alloc_dest_phys); end
    checks++; if (alloc_src1_phys !== 6'd32) begin errors++; $display("FAIL commit_src_map: got %0d expected 32", alloc_src1_phys); end
    checks++; if (free_count !== 7'd31) begin errors++; $display("FAIL commit_count_after: got %0d expected 31", free_count); end
  endtask

  task automatic test_recover();
    apply_reset();
    alloc_accepted = 1;
    offer(7, 0, 0);
    tick();
    offer(8, 0, 0);
    tick();
    checks++; if (alloc_dest_phys !== 6'd33) begin errors++; $display("FAIL rec_second_tag: got %0d expected 33", alloc_dest_phys); end
    dec_valid = 0;
    tick();
    idle();
    commit_valid = 1; commit_dest_arch = 7; commit_dest_phys = 32;
    tick();
    idle();
    recover = 1; offer(9, 0, 0);
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL rec_ready: got %0d expected 0", dec_ready); end
    tick();
    idle();
    checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL rec_valid: got %0d expected 0", alloc_valid); end
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL rec_free_count: got %0d expected 32", free_count); end
    alloc_accepted = 1;
    offer(0, 7, 8);
    tick();
    checks++; if (alloc_src1_phys !== 6'd32) begin errors++; $display("FAIL rec_map_x7: got %0d expected 32", alloc_src1_phys); end
    checks++; if (alloc_src2_phys !== 6'd8) begin errors++; $display("FAIL rec_map_x8: got %0d expected 8", alloc_src2_phys); end
    checks++; if (alloc_dest_phys !== 6'd0) begin errors++; $display("FAIL rec_x0_dest: got %0d expected 0", alloc_dest_phys); end
    offer(1, 0, 0);
    tick();
    checks++; if (alloc_dest_phys !== 6'd7) begin errors++; $display("FAIL rec_pick_7: got %0d expected 7", alloc_dest_phys); end
    offer(2, 0, 0);
    tick();
    checks++; if (alloc_dest_phys !== 6'd33) begin errors++; $display("FAIL rec_pick_33: got %0d expected 33", alloc_dest_phys); end
    idle();
  endtask

  task automatic test_same_cycle();
    apply_reset();
    alloc_accepted = 1;
    offer(4, 0, 0);
    tick();
    dec_valid = 0;
    tick();
    idle();
    commit_valid = 1; commit_dest_arch = 4; commit_dest_phys = 32;
    recover = 1; offer(3, 4, 0);
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL same_ready: got %0d expected 0", dec_ready); end
    tick();
    idle();
    checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL same_valid: got %0d expected 0", alloc_valid); end
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL same_free_count: got %0d expected 32", free_count); end
    alloc_accepted = 1;
    offer(3, 4, 0);
    tick();
    idle();
    checks++; if (alloc_dest_phys !== 6'd4) begin errors++; $display("FAIL same_pick: got %0d expected 4", alloc_dest_phys); end
    checks++; if (alloc_src1_phys !== 6'd32) begin errors++; $display("FAIL same_src_map: got %0d expected 32", alloc_src1_phys); end
    checks++; if (free_count !== 7'd31) begin errors++; $display("FAIL same_count_after: got %0d expected 31", free_count); end
  endtask

  task automatic test_random();
    bit exp_ready, acc_now, old_av;
    int d, s1, s2, pick, old_arch, old_phys, old_tag;
    apply_reset();
    m_init();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      d  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
      s1 = int'($urandom_range(0, 31));
      s2 = int'($urandom_range(0, 31));
      dec_valid      = ($urandom_range(0, 3) != 0);
      dec_dest_arch  = 5'(d); dec_src1_arch = 5'(s1); dec_src2_arch = 5'(s2);
      alloc_accepted = ($urandom_range(0, 3) != 0);
      commit_valid   = (rob_q.size() > 0) && ($urandom_range(0, 1) == 0);
      commit_dest_arch = commit_valid ? 5'(rob_q[0].arch) : 5'd0;
      commit_dest_phys = commit_valid ? 6'(rob_q[0].phys) : 6'd0;
      recover        = ($urandom_range(0, 59) == 0);
      #1;
      exp_ready = !recover && (!m_av || alloc_accepted) && (m_count() != 0 || d == 0);
      checks++; if (dec_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %0d expected %0d", cyc, dec_ready, exp_ready); end
      checks++; if (alloc_valid !== m_av) begin errors++; $display("FAIL rnd_valid@%0d: got %0d expected %0d", cyc, alloc_valid, m_av); end
      checks++; if (free_count !== 7'(m_count())) begin errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, free_count, m_count()); end
      if (m_av) begin
        checks++; if ({alloc_dest_arch, alloc_dest_phys, alloc_src1_phys, alloc_src2_phys} !== {5'(m_arch), 6'(m_phys), 6'(m_s1), 6'(m_s2)})
          begin errors++; $display("FAIL rnd_fields@%0d: got a=%0d p=%0d s1=%0d s2=%0d expected %0d/%0d/%0d/%0d", cyc, alloc_dest_arch, alloc_dest_phys, alloc_src1_phys, alloc_src2_phys, m_arch, m_phys, m_s1, m_s2); end
      end
      // Model the edge from the spec rules on the pre-edge state.
      acc_now = dec_valid && exp_ready;
      pick = m_lowest();
      old_av = m_av; old_arch = m_arch; old_phys = m_phys;
      if (commit_valid) begin
        void'(rob_q.pop_front());
        if (commit_dest_arch != 0) begin
          old_tag = m_comm[commit_dest_arch];
          m_comm[commit_dest_arch] = int'(commit_dest_phys);
          m_free[old_tag] = 1;
        end
      end
      if (recover) m_av = 0;
      else if (acc_now) begin
        m_av = 1; m_arch = d; m_s1 = m_spec[s1]; m_s2 = m_spec[s2];
        if (d != 0) begin m_phys = pick; m_free[pick] = 0; m_spec[d] = pick; end
        else m_phys = 0;
      end else if (alloc_accepted) m_av = 0;
      if (old_av && alloc_accepted) rob_q.push_back('{old_arch, old_phys});
      if (recover) begin
        m_spec = m_comm;
        for (int t = 0; t < 64; t++) m_free[t] = 1;
        for (int a = 0; a < 32; a++) m_free[m_comm[a]] = 0;
        rob_q.delete();
      end
      tick();
    end
    idle();
  endtask

  task automatic test_mid_reset();
    alloc_accepted = 1;
    offer(6, 0, 0);
    tick();
    reset = 1; offer(9, 1, 2); commit_valid = 1; commit_dest_arch = 3; commit_dest_phys = 50;
    tick();
    reset = 0; idle();
    checks++; if (alloc_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0d expected 0", alloc_valid); end
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL midrst_count: got %0d expected 32", free_count); end
    offer(5, 5, 3);
    tick();
    idle();
    checks++; if ({alloc_dest_phys, alloc_src1_phys, alloc_src2_phys} !== {6'd32, 6'd5, 6'd3})
      begin errors++; $display("FAIL midrst_alloc: got p=%0d s1=%0d s2=%0d expected 32/5/3", alloc_dest_phys, alloc_src1_phys, alloc_src2_phys); end
  endtask

  initial begin
    idle();
    reset = 0;
    @(negedge clk);
    test_reset();
    test_first_alloc();
    test_fill_free_list();
    test_hold();
    test_commit_free();
    test_recover();
    test_same_cycle();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
